// File: rtl/iob_pack_arb_if.sv
// Source/packer side bundle of iob_pack_arb: per-source read ports in,
// one muxed read port out toward the shared packer, plus grant status.
interface iob_pack_arb_if #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 21,
  parameter int BURST_W = 4
);
  localparam int WIDTH_W = $clog2(DATA_W) + 1;

  logic                       en_i;
  logic [BURST_W-1:0]         burst_i;
  logic [N_REQ-1:0]           req_rready_i;
  logic [N_REQ*DATA_W-1:0]    req_rdata_i;
  logic [N_REQ*WIDTH_W-1:0]   req_width_i;
  logic [N_REQ-1:0]           req_read_o;
  logic                       pk_rready_o;
  logic [DATA_W-1:0]          pk_rdata_o;
  logic [WIDTH_W-1:0]         pk_width_o;
  logic                       pk_read_i;
  logic [N_REQ-1:0]           grant_o;
  logic                       busy_o;

  // Arbiter side
  modport slave (
    input  en_i, burst_i, req_rready_i, req_rdata_i, req_width_i, pk_read_i,
    output req_read_o, pk_rready_o, pk_rdata_o, pk_width_o, grant_o, busy_o
  );

  // Environment side (sources + packer)
  modport master (
    output en_i, burst_i, req_rready_i, req_rdata_i, req_width_i, pk_read_i,
    input  req_read_o, pk_rready_o, pk_rdata_o, pk_width_o, grant_o, busy_o
  );
endinterface

// File: rtl/iob_pack_arb.sv
// Round-robin arbiter sharing one iob_pack packer between N_REQ sources.
// The data/width mux follows a registered grant index that only moves on
// ARB->GNT, so the packer's push cycle after a read always sees the source
// that was actually read.
module iob_pack_arb #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 21,
  parameter int BURST_W = 4
) (
  input  logic clk_i,
  input  logic cke_i,
  input  logic arst_n_i,
  input  logic rst_i,
  iob_pack_arb_if.slave bus
);
  localparam int WIDTH_W = $clog2(DATA_W) + 1;
  localparam int GIDX_W  = $clog2(N_REQ);
  localparam logic [GIDX_W-1:0] GIDX_RST = GIDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {ARB, GNT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [GIDX_W-1:0]   gidx, gidx_nxt;
  logic [BURST_W-1:0]  cnt, cnt_nxt;
  logic [N_REQ-1:0]    grant, grant_nxt;

  logic [GIDX_W-1:0]   pick;
  logic                found;
  int unsigned         scan;

  // Control registers: async reset, sync reset and clock enable
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ARB;
      gidx  <= GIDX_RST;
      cnt   <= '0;
      grant <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        state <= ARB;
        gidx  <= GIDX_RST;
        cnt   <= '0;
        grant <= '0;
      end else begin
        state <= state_nxt;
        gidx  <= gidx_nxt;
        cnt   <= cnt_nxt;
        grant <= grant_nxt;
      end
    end
  end

  // Round-robin scan: first ready source after the last grant, wrapping
  always_comb begin
    pick  = gidx;
    found = 1'b0;
    scan  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan = (int'(unsigned'(gidx)) + i) % N_REQ;
      if (!found && bus.req_rready_i[scan]) begin
        found = 1'b1;
        pick  = GIDX_W'(scan);
      end
    end
  end

  // Next-state: grant on request, count reads, end on burst or drain
  always_comb begin
    state_nxt = state;
    gidx_nxt  = gidx;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    case (state)
      ARB: begin
        if (bus.en_i && found) begin
          gidx_nxt  = pick;
          grant_nxt = N_REQ'(1) << pick;
          cnt_nxt   = '0;
          state_nxt = GNT;
        end else begin
          grant_nxt = '0;
        end
      end
      GNT: begin
        if (bus.pk_read_i) cnt_nxt = cnt + BURST_W'(1);
        if (bus.pk_read_i && (bus.burst_i != '0) &&
            (cnt == bus.burst_i - BURST_W'(1))) begin
          // Last read of the burst: one more cycle for its push
          state_nxt = HOLD;
        end else if (!bus.req_rready_i[gidx]) begin
          // Source drained; a push from last cycle's read lands now
          state_nxt = ARB;
          grant_nxt = '0;
        end
      end
      HOLD: begin
        state_nxt = ARB;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = ARB;
        grant_nxt = '0;
      end
    endcase
  end

  // Packer-facing mux and read-strobe routing
  always_comb begin
    bus.pk_rdata_o  = bus.req_rdata_i[gidx*DATA_W +: DATA_W];
    bus.pk_width_o  = bus.req_width_i[gidx*WIDTH_W +: WIDTH_W];
    bus.pk_rready_o = (state == GNT) && bus.req_rready_i[gidx];
    bus.req_read_o  = ((state == GNT) && bus.pk_read_i) ? (N_REQ'(1) << gidx) : '0;
    bus.grant_o     = grant;
    bus.busy_o      = (state != ARB);
  end
endmodule

// File: tb/tb_iob_pack_arb.sv
// Testbench for iob_pack_arb: directed scenarios plus a randomized run
// against an owner/burst reference model of the arbitration rules.
module tb_iob_pack_arb;
  localparam int N  = 4;
  localparam int DW = 21;
  localparam int BW = 4;
  localparam int WW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic cke = 1'b1;
  logic arst_n = 1'b0;
  logic rst = 1'b0;

  logic [DW-1:0] src_data  [N];
  logic [WW-1:0] src_width [N];

  int total = 0;
  int passed = 0;

  iob_pack_arb_if #(.N_REQ(N), .DATA_W(DW), .BURST_W(BW)) bus ();

  iob_pack_arb #(.N_REQ(N), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk_i   (clk),
    .cke_i   (cke),
    .arst_n_i(arst_n),
    .rst_i   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign bus.req_rdata_i[k*DW +: DW] = src_data[k];
    assign bus.req_width_i[k*WW +: WW] = src_width[k];
  end

  // Reference model: who owns the packer, whether the post-burst push cycle
  // is pending, reads taken in this grant, and the last source granted.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_reads = 0;
  bit m_hold  = 1'b0;

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_owner <= -1; m_last <= N - 1; m_reads <= 0; m_hold <= 1'b0;
    end else if (cke) begin
      if (rst) begin
        m_owner <= -1; m_last <= N - 1; m_reads <= 0; m_hold <= 1'b0;
      end else if (m_owner < 0) begin
        if (bus.en_i && rr_pick(m_last, bus.req_rready_i) >= 0) begin
          m_owner <= rr_pick(m_last, bus.req_rready_i);
          m_last  <= rr_pick(m_last, bus.req_rready_i);
          m_reads <= 0;
          m_hold  <= 1'b0;
        end
      end else if (m_hold) begin
        m_owner <= -1;
        m_hold  <= 1'b0;
      end else begin
        if (bus.pk_read_i) m_reads <= (m_reads + 1) % (1 << BW);
        if (bus.pk_read_i && bus.burst_i != 0 &&
            ((m_reads + 1) % (1 << BW)) == int'(bus.burst_i))
          m_hold <= 1'b1;
        else if (!bus.req_rready_i[m_owner])
          m_owner <= -1;
      end
    end
  end

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic exp_rready();
    return (m_owner >= 0) && !m_hold && bus.req_rready_i[m_owner];
  endfunction

  function automatic logic [N-1:0] exp_read();
    return ((m_owner >= 0) && !m_hold && bus.pk_read_i) ? N'(1 << m_owner) : '0;
  endfunction

  task automatic do_reset();
    arst_n = 1'b0; rst = 1'b0; cke = 1'b1;
    bus.en_i = 1'b0; bus.req_rready_i = '0; bus.pk_read_i = 1'b0; bus.burst_i = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.en_i = 1'b1; bus.req_rready_i = 4'b1111; bus.pk_read_i = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", bus.grant_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy_o); else passed++;
    total++; if (bus.pk_rready_o !== 1'b0) $display("FAIL reset_rready got=%b exp=0", bus.pk_rready_o); else passed++;
    total++; if (bus.req_read_o !== 4'b0000) $display("FAIL reset_read got=%b exp=0000", bus.req_read_o); else passed++;
    total++; if (bus.pk_rdata_o !== src_data[3]) $display("FAIL reset_mux got=%h exp=%h", bus.pk_rdata_o, src_data[3]); else passed++;
    bus.pk_read_i = 1'b0;
  endtask

  task automatic test_single_burst();
    int nreads;
    do_reset();
    src_width[0] = 6'd7; bus.burst_i = 4'd4; bus.req_rready_i = 4'b0001; bus.en_i = 1'b1;
    #1;
    total++; if (bus.grant_o !== 4'b0000) $display("FAIL sb_latency got=%b exp=0000", bus.grant_o); else passed++;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL sb_grant got=%b exp=0001", bus.grant_o); else passed++;
    total++; if (bus.pk_rready_o !== 1'b1 || bus.busy_o !== 1'b1) $display("FAIL sb_gnt_flags got=%b%b exp=11", bus.pk_rready_o, bus.busy_o); else passed++;
    total++; if (bus.pk_width_o !== 6'd7) $display("FAIL sb_width got=%0d exp=7", bus.pk_width_o); else passed++;
    nreads = 0;
    for (int r = 0; r < 4; r++) begin
      repeat (3) @(negedge clk);
      bus.pk_read_i = 1'b1; #1;
      if (bus.req_read_o === 4'b0001) nreads++;
      @(negedge clk);
      bus.pk_read_i = 1'b0;
    end
    #1;
    total++; if (nreads != 4) $display("FAIL sb_reads got=%0d exp=4", nreads); else passed++;
    total++; if (bus.grant_o !== 4'b0001 || bus.pk_rready_o !== 1'b0 || bus.busy_o !== 1'b1)
      $display("FAIL sb_hold got=%b/%b/%b exp=0001/0/1", bus.grant_o, bus.pk_rready_o, bus.busy_o); else passed++;
    bus.pk_read_i = 1'b1; #1;
    total++; if (bus.req_read_o !== 4'b0000) $display("FAIL sb_hold_read got=%b exp=0000", bus.req_read_o); else passed++;
    @(negedge clk);
    bus.pk_read_i = 1'b0; #1;
    total++; if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) $display("FAIL sb_arb got=%b/%b exp=0000/0", bus.grant_o, bus.busy_o); else passed++;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL sb_regrant got=%b exp=0001", bus.grant_o); else passed++;
  endtask

  task automatic test_alternate();
    int src;
    do_reset();
    src_width[0] = 6'd5; src_width[1] = 6'd12;
    bus.burst_i = 4'd2; bus.req_rready_i = 4'b0011; bus.en_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      src = g % 2;
      @(negedge clk); #1;
      total++; if (bus.grant_o !== N'(1 << src)) $display("FAIL alt_grant%0d got=%b exp=%b", g, bus.grant_o, N'(1 << src)); else passed++;
      total++; if (bus.pk_width_o !== src_width[src]) $display("FAIL alt_width%0d got=%0d exp=%0d", g, bus.pk_width_o, src_width[src]); else passed++;
      bus.pk_read_i = 1'b1; #1;
      total++; if (bus.req_read_o !== N'(1 << src)) $display("FAIL alt_read1_%0d got=%b exp=%b", g, bus.req_read_o, N'(1 << src)); else passed++;
      @(negedge clk); bus.pk_read_i = 1'b0;
      @(negedge clk); bus.pk_read_i = 1'b1; #1;
      total++; if (bus.req_read_o !== N'(1 << src)) $display("FAIL alt_read2_%0d got=%b exp=%b", g, bus.req_read_o, N'(1 << src)); else passed++;
      @(negedge clk); bus.pk_read_i = 1'b0; #1;
      total++; if (bus.grant_o !== N'(1 << src) || bus.pk_rready_o !== 1'b0 || bus.pk_width_o !== src_width[src])
        $display("FAIL alt_hold%0d got=%b/%b/%0d exp=%b/0/%0d", g, bus.grant_o, bus.pk_rready_o, bus.pk_width_o, N'(1 << src), src_width[src]); else passed++;
      @(negedge clk); #1;
      total++; if (bus.grant_o !== 4'b0000 || bus.pk_width_o !== src_width[src])
        $display("FAIL alt_arb%0d got=%b/%0d exp=0000/%0d", g, bus.grant_o, bus.pk_width_o, src_width[src]); else passed++;
    end
  endtask

  task automatic test_drain();
    do_reset();
    bus.burst_i = 4'd0; bus.req_rready_i = 4'b0100; bus.en_i = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0100) $display("FAIL dr_grant got=%b exp=0100", bus.grant_o); else passed++;
    bus.pk_read_i = 1'b1; @(negedge clk); bus.pk_read_i = 1'b0;
    @(negedge clk); bus.pk_read_i = 1'b1; @(negedge clk); bus.pk_read_i = 1'b0;
    @(negedge clk); bus.pk_read_i = 1'b1; #1;
    total++; if (bus.req_read_o !== 4'b0100) $display("FAIL dr_read3 got=%b exp=0100", bus.req_read_o); else passed++;
    @(negedge clk);
    bus.pk_read_i = 1'b0; bus.req_rready_i = 4'b1000; #1;
    total++; if (bus.pk_rdata_o !== src_data[2] || bus.grant_o !== 4'b0100)
      $display("FAIL dr_push got=%h/%b exp=%h/0100", bus.pk_rdata_o, bus.grant_o, src_data[2]); else passed++;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.pk_rdata_o !== src_data[2])
      $display("FAIL dr_arb got=%b/%b/%h exp=0000/0/%h", bus.grant_o, bus.busy_o, bus.pk_rdata_o, src_data[2]); else passed++;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b1000 || bus.pk_rdata_o !== src_data[3])
      $display("FAIL dr_next got=%b/%h exp=1000/%h", bus.grant_o, bus.pk_rdata_o, src_data[3]); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    bus.en_i = 1'b1; bus.burst_i = 4'd0; bus.req_rready_i = 4'b1000;
    @(negedge clk); bus.req_rready_i = 4'b0000;
    @(negedge clk); bus.req_rready_i = 4'b1111;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL prio_after3 got=%b exp=0001", bus.grant_o); else passed++;
    bus.req_rready_i = 4'b0000;
    @(negedge clk); bus.req_rready_i = 4'b0010;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0010) $display("FAIL prio_grant1 got=%b exp=0010", bus.grant_o); else passed++;
    bus.req_rready_i = 4'b0000;
    @(negedge clk); bus.req_rready_i = 4'b1111;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0100) $display("FAIL prio_after1 got=%b exp=0100", bus.grant_o); else passed++;
  endtask

  task automatic test_resets();
    do_reset();
    bus.burst_i = 4'd4; bus.req_rready_i = 4'b0011; bus.en_i = 1'b1;
    @(negedge clk);
    bus.pk_read_i = 1'b1; @(negedge clk); bus.pk_read_i = 1'b0;
    @(negedge clk); bus.pk_read_i = 1'b1; @(negedge clk); bus.pk_read_i = 1'b0;
    #2 arst_n = 1'b0; #1;
    total++; if (bus.grant_o !== 4'b0000 || bus.pk_rready_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL arst_mid got=%b/%b/%b exp=0000/0/0", bus.grant_o, bus.pk_rready_o, bus.busy_o); else passed++;
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL arst_regrant got=%b exp=0001", bus.grant_o); else passed++;
    rst = 1'b1; #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL srst_before_edge got=%b exp=0001", bus.grant_o); else passed++;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) $display("FAIL srst got=%b/%b exp=0000/0", bus.grant_o, bus.busy_o); else passed++;
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL srst_regrant got=%b exp=0001", bus.grant_o); else passed++;
  endtask

  task automatic test_enable();
    do_reset();
    bus.req_rready_i = 4'b1111; bus.en_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) $display("FAIL en_off%0d got=%b/%b exp=0000/0", c, bus.grant_o, bus.busy_o); else passed++;
    end
    bus.en_i = 1'b1; bus.burst_i = 4'd2;
    @(negedge clk); #1;
    total++; if (bus.grant_o !== 4'b0001) $display("FAIL en_grant got=%b exp=0001", bus.grant_o); else passed++;
    bus.en_i = 1'b0;
    bus.pk_read_i = 1'b1; @(negedge clk); bus.pk_read_i = 1'b0;
    @(negedge clk); bus.pk_read_i = 1'b1; @(negedge clk); bus.pk_read_i = 1'b0; #1;
    total++; if (bus.grant_o !== 4'b0001 || bus.busy_o !== 1'b1) $display("FAIL en_complete got=%b/%b exp=0001/1", bus.grant_o, bus.busy_o); else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (bus.grant_o !== 4'b0000) $display("FAIL en_nogrant%0d got=%b exp=0000", c, bus.grant_o); else passed++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      cke = ($urandom % 8) != 0;
      rst = ($urandom % 64) == 0;
      bus.en_i = ($urandom % 8) != 0;
      bus.req_rready_i = N'($urandom);
      bus.burst_i = BW'($urandom % 5);
      if ($urandom % 4 == 0)
        for (int k = 0; k < N; k++) begin
          src_data[k]  = DW'($urandom);
          src_width[k] = WW'($urandom % (DW + 1));
        end
      bus.pk_read_i = exp_rready() && ($urandom % 2 == 0);
      #1;
      total++; if (bus.grant_o !== exp_grant()) $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, bus.grant_o, exp_grant()); else passed++;
      total++; if (bus.busy_o !== (m_owner >= 0)) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy_o, m_owner >= 0); else passed++;
      total++; if (bus.pk_rready_o !== exp_rready()) $display("FAIL rnd_rready c=%0d got=%b exp=%b", c, bus.pk_rready_o, exp_rready()); else passed++;
      total++; if (bus.req_read_o !== exp_read()) $display("FAIL rnd_read c=%0d got=%b exp=%b", c, bus.req_read_o, exp_read()); else passed++;
      total++; if (bus.pk_rdata_o !== src_data[m_last]) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.pk_rdata_o, src_data[m_last]); else passed++;
      total++; if (bus.pk_width_o !== src_width[m_last]) $display("FAIL rnd_width c=%0d got=%0d exp=%0d", c, bus.pk_width_o, src_width[m_last]); else passed++;
    end
    cke = 1'b1; rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      src_data[k]  = DW'(32'h1A5A0 + k * 32'h11111);
      src_width[k] = WW'(k + 3);
    end
    bus.en_i = 1'b0; bus.req_rready_i = '0; bus.pk_read_i = 1'b0; bus.burst_i = '0;
    test_reset();
    test_single_burst();
    test_alternate();
    test_drain();
    test_priority();
    test_resets();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
